// File: rtl/murra232_gate_unit.sv
// murra232_gate_unit: WIDTH-bit bitwise logic unit with a run-time selectable
// operation, a registered result with a valid strobe, and a truth-table sweep
// mode that walks every operand combination and folds each result into a
// rotating signature register for self-test.
module murra232_gate_unit #(
    parameter int WIDTH = 2,   // operand/result width, legal range 1..4
    parameter int SIG_W = 8    // signature width, must be >= WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [2:0]       op_i,
    input  logic             op_load,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             in_valid,
    input  logic             sweep_start,
    output logic [WIDTH-1:0] y_o,
    output logic             out_valid,
    output logic             busy,
    output logic             sweep_done,
    output logic [SIG_W-1:0] sig_o
);

    // The sweep counter concatenates operand B (upper half) and operand A
    // (lower half), so it has to cover every pair of WIDTH-bit operands.
    localparam int CNT_W = 2 * WIDTH;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Operation codes, applied bitwise to the operands.
    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;

    state_t             state_q,      state_d;
    logic [2:0]         op_q,         op_d;
    logic [WIDTH-1:0]   y_q,          y_d;
    logic               out_valid_q,  out_valid_d;
    logic               sweep_done_q, sweep_done_d;
    logic [SIG_W-1:0]   sig_q,        sig_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;

    logic [WIDTH-1:0]   sweep_a;
    logic [WIDTH-1:0]   sweep_b;
    logic [WIDTH-1:0]   sweep_res;
    logic [WIDTH-1:0]   norm_res;

    // Bitwise function selected by the op register.
    function automatic logic [WIDTH-1:0] gate_fn(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_NAND: r = ~(a & b);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    // Rotate left by one; for a 1-bit signature this degenerates to identity.
    function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] s);
        return (s << 1) | (s >> (SIG_W - 1));
    endfunction

    // Split the sweep counter into the operand pair it currently represents.
    always_comb begin
        sweep_a   = cnt_q[WIDTH-1:0];
        sweep_b   = cnt_q[CNT_W-1:WIDTH];
        sweep_res = gate_fn(op_q, sweep_a, sweep_b);
        norm_res  = gate_fn(op_q, a_i, b_i);
    end

    // Next-state logic: strobes default low, everything else holds unless
    // an enabled edge in IDLE or SWEEP says otherwise.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        y_d          = y_q;
        out_valid_d  = 1'b0;
        sweep_done_d = 1'b0;
        sig_d        = sig_q;
        cnt_d        = cnt_q;

        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    // The op register loads even on a sweep start edge, so
                    // the sweep runs with the freshly loaded op; a sample on
                    // the same edge still uses the old op.
                    if (op_load) begin
                        op_d = op_i;
                    end
                    if (sweep_start) begin
                        state_d = ST_SWEEP;
                        cnt_d   = '0;
                        sig_d   = '0;
                    end else if (in_valid) begin
                        y_d         = norm_res;
                        out_valid_d = 1'b1;
                    end
                end
                ST_SWEEP: begin
                    y_d         = sweep_res;
                    out_valid_d = 1'b1;
                    sig_d       = rotl1(sig_q) ^ SIG_W'(sweep_res);
                    cnt_d       = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        sweep_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NAND;
            y_q          <= '0;
            out_valid_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            sig_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            y_q          <= y_d;
            out_valid_q  <= out_valid_d;
            sweep_done_q <= sweep_done_d;
            sig_q        <= sig_d;
            cnt_q        <= cnt_d;
        end
    end

    assign y_o        = y_q;
    assign out_valid  = out_valid_q;
    assign sweep_done = sweep_done_q;
    assign sig_o      = sig_q;
    assign busy       = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_murra232_gate_unit.sv
// Testbench for murra232_gate_unit: a WIDTH=2 instance exercises normal mode,
// sweeps, ena gating and reset; a WIDTH=1 instance checks the small sweep.
// Expected results are queued when stimulus is driven and popped by monitors.
module tb_murra232_gate_unit;

    typedef struct packed {
        logic [3:0] y;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] op_i;
    logic       op_load;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       in_valid;
    logic       sweep_start2;
    logic [1:0] y2;
    logic       out_valid2;
    logic       busy2;
    logic       done2;
    logic [7:0] sig2;

    logic       op_load1;
    logic       a1;
    logic       b1;
    logic       in_valid1;
    logic       sweep_start1;
    logic       y1;
    logic       out_valid1;
    logic       busy1;
    logic       done1;
    logic [7:0] sig1;

    int   num_checks = 0;
    int   num_errors = 0;
    exp_t exp2[$];
    exp_t exp1[$];
    int   valid_count2 = 0;
    int   busy_count2  = 0;
    int   busy_count1  = 0;
    logic [2:0] model_op = 3'd0;

    murra232_gate_unit #(.WIDTH(2), .SIG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .op_i(op_i), .op_load(op_load),
        .a_i(a2), .b_i(b2), .in_valid(in_valid), .sweep_start(sweep_start2),
        .y_o(y2), .out_valid(out_valid2), .busy(busy2), .sweep_done(done2),
        .sig_o(sig2)
    );

    murra232_gate_unit #(.WIDTH(1), .SIG_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .op_i(op_i), .op_load(op_load1),
        .a_i(a1), .b_i(b1), .in_valid(in_valid1), .sweep_start(sweep_start1),
        .y_o(y1), .out_valid(out_valid1), .busy(busy1), .sweep_done(done1),
        .sig_o(sig1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        num_checks++;
        if (got !== expv) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic [3:0] modelGate(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b, input int w);
        logic [3:0] r;
        logic [3:0] m;
        case (op)
            3'd0: r = ~(a & b);
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = ~(a | b);
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: r = ~a;
            default: r = a;
        endcase
        m = 4'((1 << w) - 1);
        return r & m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One normal-mode sample on the WIDTH=2 unit, optionally loading a new op.
    task automatic applyStimulus(input logic [2:0] op, input logic ld,
                                 input logic [1:0] a, input logic [1:0] b);
        exp_t e;
        op_i     = op;
        op_load  = ld;
        a2       = a;
        b2       = b;
        in_valid = 1'b1;
        e.y      = modelGate(model_op, {2'b00, a}, {2'b00, b}, 2);
        e.done   = 1'b0;
        exp2.push_back(e);
        if (ld) model_op = op;
        tick();
        in_valid = 1'b0;
        op_load  = 1'b0;
    endtask

    // Queue the expected results of sweep combinations 0..n-1 and return the
    // signature a complete run would leave behind.
    task automatic pushSweep2(input logic [2:0] op, input int n, output logic [7:0] sig);
        exp_t e;
        logic [3:0] cv;
        sig = 8'h00;
        for (int c = 0; c < 16; c++) begin
            cv     = c[3:0];
            e.y    = modelGate(op, {2'b00, cv[1:0]}, {2'b00, cv[3:2]}, 2);
            e.done = (c == 15);
            sig    = {sig[6:0], sig[7]} ^ {4'b0000, e.y};
            if (c < n) exp2.push_back(e);
        end
    endtask

    task automatic waitDone2(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done2) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    // Scoreboard monitor for the WIDTH=2 unit.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst_n) begin
            if (out_valid2) begin
                valid_count2++;
                checkOutput("y2_sb_pending", 32'(exp2.size() > 0), 32'd1);
                if (exp2.size() > 0) begin
                    e = exp2.pop_front();
                    checkOutput("y2", 32'(y2), 32'(e.y));
                    checkOutput("done2", 32'(done2), 32'(e.done));
                end
            end else if (done2) begin
                checkOutput("done2_needs_valid", 32'(out_valid2), 32'd1);
            end
            if (busy2) busy_count2++;
        end
    end

    // Scoreboard monitor for the WIDTH=1 unit.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n) begin
            if (out_valid1) begin
                checkOutput("y1_sb_pending", 32'(exp1.size() > 0), 32'd1);
                if (exp1.size() > 0) begin
                    e = exp1.pop_front();
                    checkOutput("y1", 32'(y1), 32'(e.y));
                    checkOutput("done1", 32'(done1), 32'(e.done));
                end
            end else if (done1) begin
                checkOutput("done1_needs_valid", 32'(out_valid1), 32'd1);
            end
            if (busy1) busy_count1++;
        end
    end

    initial begin
        logic [7:0] exp_sig;
        exp_t e;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [2:0] rop;
        bit seen1;

        rst_n = 1'b0; ena = 1'b1; op_i = 3'd0; op_load = 1'b0;
        a2 = 2'b00; b2 = 2'b00; in_valid = 1'b0; sweep_start2 = 1'b0;
        op_load1 = 1'b0; a1 = 1'b0; b1 = 1'b0; in_valid1 = 1'b0; sweep_start1 = 1'b0;

        // Reset state.
        #3;
        checkOutput("rst_y", 32'(y2), 32'd0);
        checkOutput("rst_valid", 32'(out_valid2), 32'd0);
        checkOutput("rst_busy", 32'(busy2), 32'd0);
        checkOutput("rst_done", 32'(done2), 32'd0);
        checkOutput("rst_sig", 32'(sig2), 32'd0);
        checkOutput("rst_sig1", 32'(sig1), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset default op is NAND; then op load with a coincident sample.
        applyStimulus(3'd0, 1'b0, 2'b11, 2'b11);
        tick();
        applyStimulus(3'd4, 1'b1, 2'b10, 2'b11);
        applyStimulus(3'd0, 1'b0, 2'b10, 2'b11);
        applyStimulus(3'd1, 1'b1, 2'b00, 2'b00);
        applyStimulus(3'd0, 1'b0, 2'b10, 2'b11);
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 2'($urandom_range(0, 3));
            rb  = 2'($urandom_range(0, 3));
            applyStimulus(rop, 1'($urandom_range(0, 1)), ra, rb);
        end
        tick();
        tick();

        // WIDTH=1 NAND sweep: 1,1,1,0 with done on the last result.
        for (int c = 0; c < 4; c++) begin
            e.y    = (c == 3) ? 4'd0 : 4'd1;
            e.done = (c == 3);
            exp1.push_back(e);
        end
        busy_count1  = 0;
        sweep_start1 = 1'b1;
        tick();
        sweep_start1 = 1'b0;
        seen1 = 1'b0;
        for (int i = 0; i < 12 && !seen1; i++) begin
            tick();
            if (done1) seen1 = 1'b1;
        end
        checkOutput("sweep1_done_seen", 32'(seen1), 32'd1);
        checkOutput("sig1", 32'(sig1), 32'h0E);
        tick();
        checkOutput("busy1_cycles", 32'(busy_count1), 32'd4);

        // Full WIDTH=2 sweep with XOR loaded on the start edge, with ignored
        // in_valid, op_load and sweep_start pulses mid-sweep.
        model_op = 3'd4;
        pushSweep2(3'd4, 16, exp_sig);
        valid_count2 = 0;
        busy_count2  = 0;
        op_i = 3'd4; op_load = 1'b1; sweep_start2 = 1'b1;
        tick();
        op_load = 1'b0; sweep_start2 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        op_i = 3'd1; op_load = 1'b1; in_valid = 1'b1; sweep_start2 = 1'b1;
        a2 = 2'b11; b2 = 2'b01;
        tick();
        op_load = 1'b0; in_valid = 1'b0; sweep_start2 = 1'b0;
        waitDone2(40, "sweep2_done_seen");
        checkOutput("sig2_xor", 32'(sig2), 32'(exp_sig));
        tick();
        tick();
        checkOutput("valid2_count", 32'(valid_count2), 32'd16);
        checkOutput("busy2_cycles", 32'(busy_count2), 32'd16);
        checkOutput("sig2_hold", 32'(sig2), 32'(exp_sig));
        applyStimulus(3'd0, 1'b0, 2'b10, 2'b11);
        tick();

        // ena gating mid-sweep: NOR sweep paused for three edges.
        model_op = 3'd3;
        pushSweep2(3'd3, 16, exp_sig);
        op_i = 3'd3; op_load = 1'b1; sweep_start2 = 1'b1;
        tick();
        op_load = 1'b0; sweep_start2 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("gap_valid", 32'(out_valid2), 32'd0);
            checkOutput("gap_busy", 32'(busy2), 32'd1);
        end
        ena = 1'b1;
        waitDone2(30, "sweep_gated_done_seen");
        checkOutput("sig2_gated", 32'(sig2), 32'(exp_sig));
        tick();
        tick();

        // Reset in the middle of an AND sweep, at combination 5.
        model_op = 3'd1;
        pushSweep2(3'd1, 5, exp_sig);
        op_i = 3'd1; op_load = 1'b1; sweep_start2 = 1'b1;
        tick();
        op_load = 1'b0; sweep_start2 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy2), 32'd0);
        checkOutput("midrst_valid", 32'(out_valid2), 32'd0);
        checkOutput("midrst_done", 32'(done2), 32'd0);
        checkOutput("midrst_sig", 32'(sig2), 32'd0);
        checkOutput("midrst_y", 32'(y2), 32'd0);
        model_op = 3'd0;
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(3'd0, 1'b0, 2'b11, 2'b01);
        tick();
        tick();

        checkOutput("sb2_empty", 32'(exp2.size()), 32'd0);
        checkOutput("sb1_empty", 32'(exp1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
